// File: rtl/multisim_client_apb_push.sv
// APB completer for the client side of the multisim APB bridge.
// Each APB transfer is packed into a request word and pushed out. The access
// phase is held with PREADY low until the matching response word is pulled
// back in, or until the optional response timeout expires.
module multisim_client_apb_push #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int STALE_W        = 4
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           i_apb_s_psel,
    input  logic                                           i_apb_s_penable,
    input  logic                                           i_apb_s_pwrite,
    input  logic [ADDR_WIDTH-1:0]                          i_apb_s_paddr,
    input  logic [DATA_WIDTH-1:0]                          i_apb_s_pwdata,
    input  logic [DATA_WIDTH/8-1:0]                        i_apb_s_pstrb,
    output logic                                           o_apb_s_pready,
    output logic [DATA_WIDTH-1:0]                          o_apb_s_prdata,
    output logic                                           o_apb_s_pslverr,
    output logic                                           o_req_vld,
    input  logic                                           i_req_rdy,
    output logic [ADDR_WIDTH+DATA_WIDTH+DATA_WIDTH/8:0]    o_req_data,
    input  logic                                           i_resp_vld,
    output logic                                           o_resp_rdy,
    input  logic [DATA_WIDTH:0]                            i_resp_data,
    output logic                                           o_timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [STALE_W-1:0] STALE_MAX = '1;

    state_t               state;
    logic [31:0]          to_cnt;
    logic [STALE_W-1:0]   stale_cnt;
    logic                 expire;

    // Timeout fires when the wait counter reaches its last cycle; disabled when 0.
    assign expire = (TIMEOUT_CYCLES > 0) && (to_cnt >= 32'(TIMEOUT_CYCLES - 1));

    // Handshake strobes decode straight from the state.
    assign o_req_vld      = (state == REQ);
    assign o_resp_rdy     = (state == WAIT);
    assign o_apb_s_pready = (state == DONE);

    // Transfer sequencing, request capture, response/timeout handling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            o_req_data      <= '0;
            o_apb_s_prdata  <= '0;
            o_apb_s_pslverr <= 1'b0;
            o_timeout       <= 1'b0;
            to_cnt          <= '0;
            stale_cnt       <= '0;
        end else begin
            o_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    // Only the setup phase starts a transfer.
                    if (i_apb_s_psel && !i_apb_s_penable) begin
                        o_req_data <= {i_apb_s_pwrite, i_apb_s_paddr,
                                       i_apb_s_pwdata, i_apb_s_pstrb};
                        state      <= REQ;
                    end
                end
                REQ: begin
                    // The request may stall forever; no timeout runs here.
                    if (i_req_rdy) begin
                        state  <= WAIT;
                        to_cnt <= '0;
                    end
                end
                WAIT: begin
                    if (i_resp_vld) begin
                        if (stale_cnt != '0) begin
                            // Word belongs to an earlier timed-out transfer.
                            stale_cnt <= stale_cnt - 1'b1;
                            if (to_cnt != '1) to_cnt <= to_cnt + 1'b1;
                        end else begin
                            o_apb_s_prdata  <= i_resp_data[DATA_WIDTH-1:0];
                            o_apb_s_pslverr <= i_resp_data[DATA_WIDTH];
                            state           <= DONE;
                        end
                    end else if (expire) begin
                        // Its response is still owed and must be discarded later.
                        o_apb_s_prdata  <= '0;
                        o_apb_s_pslverr <= 1'b1;
                        o_timeout       <= 1'b1;
                        if (stale_cnt != STALE_MAX) stale_cnt <= stale_cnt + 1'b1;
                        state           <= DONE;
                    end else if (to_cnt != '1) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multisim_client_apb_push.sv
// Directed bench for multisim_client_apb_push. Two instances share every
// input: u_dut0 has no timeout, u_dut8 times out after 8 wait cycles.
module tb_multisim_client_apb_push;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int RW = 1 + AW + DW + SW;

    logic          clk = 1'b0;
    logic          rst;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [SW-1:0] pstrb;
    logic          req_rdy, resp_vld;
    logic [DW:0]   resp_data;

    logic          pready0, pslverr0, req_vld0, resp_rdy0, timeout0;
    logic [DW-1:0] prdata0;
    logic [RW-1:0] req_data0;
    logic          pready8, pslverr8, req_vld8, resp_rdy8, timeout8;
    logic [DW-1:0] prdata8;
    logic [RW-1:0] req_data8;

    int checks   = 0;
    int failures = 0;
    int bad;

    always #5 clk = ~clk;

    multisim_client_apb_push #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(0), .STALE_W(4)) u_dut0 (
        .clk(clk), .rst(rst),
        .i_apb_s_psel(psel), .i_apb_s_penable(penable), .i_apb_s_pwrite(pwrite),
        .i_apb_s_paddr(paddr), .i_apb_s_pwdata(pwdata), .i_apb_s_pstrb(pstrb),
        .o_apb_s_pready(pready0), .o_apb_s_prdata(prdata0), .o_apb_s_pslverr(pslverr0),
        .o_req_vld(req_vld0), .i_req_rdy(req_rdy), .o_req_data(req_data0),
        .i_resp_vld(resp_vld), .o_resp_rdy(resp_rdy0), .i_resp_data(resp_data),
        .o_timeout(timeout0)
    );

    multisim_client_apb_push #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8), .STALE_W(4)) u_dut8 (
        .clk(clk), .rst(rst),
        .i_apb_s_psel(psel), .i_apb_s_penable(penable), .i_apb_s_pwrite(pwrite),
        .i_apb_s_paddr(paddr), .i_apb_s_pwdata(pwdata), .i_apb_s_pstrb(pstrb),
        .o_apb_s_pready(pready8), .o_apb_s_prdata(prdata8), .o_apb_s_pslverr(pslverr8),
        .o_req_vld(req_vld8), .i_req_rdy(req_rdy), .o_req_data(req_data8),
        .i_resp_vld(resp_vld), .o_resp_rdy(resp_rdy8), .i_resp_data(resp_data),
        .o_timeout(timeout8)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; everything after returns 1ns past the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a setup phase, let it be captured, then enter the access phase.
    task automatic apb_setup(input logic w, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic [SW-1:0] s);
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d; pstrb = s;
        step();
        penable = 1'b1;
    endtask

    task automatic apb_end();
        psel = 1'b0; penable = 1'b0;
    endtask

    logic [RW-1:0] exp_req;

    initial begin
        rst = 1'b1; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0; pstrb = '0;
        req_rdy = 0; resp_vld = 0; resp_data = '0;
        repeat (2) step();
        chk("rst_pready", pready8, 0);
        chk("rst_req_vld", req_vld8, 0);
        chk("rst_req_data", req_data8, 0);
        chk("rst_prdata", prdata8, 0);
        rst = 1'b0;
        step();

        // 1: minimum latency write, rdy/vld tied high
        req_rdy = 1; resp_vld = 1; resp_data = '0;
        apb_setup(1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
        exp_req = {1'b1, 32'h100, 32'hDEADBEEF, 4'hF};
        chk("t1_req_vld", req_vld0, 1);
        chk("t1_req_data", req_data0, exp_req);
        chk("t1_pready_req", pready0, 0);
        step();
        chk("t1_req_vld_off", req_vld0, 0);
        chk("t1_resp_rdy", resp_rdy0, 1);
        chk("t1_pready_wait", pready0, 0);
        step();
        chk("t1_pready", pready0, 1);
        chk("t1_pready8", pready8, 1);
        chk("t1_pslverr", pslverr0, 0);
        apb_end();
        step();
        chk("t1_pready_off", pready0, 0);

        // 2: read, response 10 cycles after acceptance (no-timeout instance)
        resp_vld = 0;
        apb_setup(1'b0, 32'h20, 32'h0, 4'h0);
        step();                         // acceptance edge
        bad = 0;
        for (int i = 0; i < 9; i++) begin
            if (pready0 !== 1'b0) bad++;
            step();
        end
        if (pready0 !== 1'b0) bad++;
        chk("t2_pready_early", bad, 0);
        resp_vld = 1; resp_data = {1'b0, 32'h12345678};
        step();
        resp_vld = 0;
        chk("t2_pready", pready0, 1);
        chk("t2_prdata", prdata0, 32'h12345678);
        chk("t2_pslverr", pslverr0, 0);
        apb_end();
        step();

        // Clear the timed-out state of the timeout instance.
        rst = 1'b1; step(); rst = 1'b0; step();

        // 3: request stalls 50 cycles, no timeout
        req_rdy = 0;
        apb_setup(1'b1, 32'h44, 32'hCAFEF00D, 4'h3);
        exp_req = {1'b1, 32'h44, 32'hCAFEF00D, 4'h3};
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (req_vld8 !== 1'b1 || req_data8 !== exp_req || timeout8 !== 1'b0 || pready8 !== 1'b0) bad++;
            step();
        end
        chk("t3_stall_stable", bad, 0);
        req_rdy = 1;
        step();
        req_rdy = 0;
        resp_vld = 1; resp_data = {1'b0, 32'h0000BEEF};
        step();
        resp_vld = 0;
        chk("t3_pready", pready8, 1);
        chk("t3_prdata", prdata8, 32'h0000BEEF);
        apb_end();
        step();

        // 4: timeout, then stale response dropped
        req_rdy = 1;
        apb_setup(1'b0, 32'h80, 32'h0, 4'h0);
        step();                         // acceptance edge
        bad = 0;
        for (int i = 0; i < 7; i++) begin
            step();
            if (timeout8 !== 1'b0 || pready8 !== 1'b0) bad++;
        end
        chk("t4_no_early_timeout", bad, 0);
        step();
        chk("t4_timeout", timeout8, 1);
        chk("t4_pready", pready8, 1);
        chk("t4_pslverr", pslverr8, 1);
        chk("t4_prdata", prdata8, 0);
        apb_end();
        step();
        chk("t4_timeout_pulse", timeout8, 0);
        apb_setup(1'b0, 32'h84, 32'h0, 4'h0);
        step();                         // in WAIT
        resp_vld = 1; resp_data = {1'b0, 32'h0000AAAA};
        step();
        chk("t4_stale_dropped", pready8, 0);
        chk("t4_stale_prdata", prdata8, 0);
        resp_data = {1'b0, 32'h00005555};
        step();
        resp_vld = 0;
        chk("t4_next_pready", pready8, 1);
        chk("t4_next_prdata", prdata8, 32'h00005555);
        chk("t4_next_pslverr", pslverr8, 0);
        apb_end();
        step();

        // 5: response coincides with timeout expiry
        apb_setup(1'b0, 32'h88, 32'h0, 4'h0);
        step();                         // acceptance edge
        repeat (7) step();
        resp_vld = 1; resp_data = {1'b0, 32'h00000077};
        step();
        resp_vld = 0;
        chk("t5_pready", pready8, 1);
        chk("t5_prdata", prdata8, 32'h77);
        chk("t5_no_timeout", timeout8, 0);
        apb_end();
        step();
        apb_setup(1'b0, 32'h8C, 32'h0, 4'h0);
        step();
        resp_vld = 1; resp_data = {1'b0, 32'h00000099};
        step();
        resp_vld = 0;
        chk("t5_not_stale", pready8, 1);
        chk("t5_not_stale_data", prdata8, 32'h99);
        apb_end();
        step();

        // 6: asynchronous reset in WAIT, then a normal transfer
        apb_setup(1'b1, 32'h90, 32'h11112222, 4'hF);
        step();
        chk("t6_in_wait", resp_rdy8, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_resp_rdy", resp_rdy8, 0);
        chk("t6_rst_req_data", req_data8, 0);
        chk("t6_rst_prdata", prdata8, 0);
        chk("t6_rst_pready", pready8, 0);
        apb_end();
        step();
        rst = 1'b0;
        step();
        chk("t6_idle_pready", pready8, 0);
        resp_vld = 1; resp_data = {1'b1, 32'h00000042};
        apb_setup(1'b0, 32'h94, 32'h0, 4'h0);
        chk("t6_req_vld", req_vld8, 1);
        step();
        step();
        chk("t6_pready", pready8, 1);
        chk("t6_prdata", prdata8, 32'h42);
        chk("t6_pslverr", pslverr8, 1);
        resp_vld = 0;
        apb_end();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
